// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, sequencer state encoding,
// error codes, and the opcode validity check.
// The ALU, the UART sequencer and the top-level bench all import this package.
package alu_pkg;

   localparam int NB_OP_PKG = 6;

   localparam logic [NB_OP_PKG-1:0] ADD_OP = 6'b100000;
   localparam logic [NB_OP_PKG-1:0] SUB_OP = 6'b100010;
   localparam logic [NB_OP_PKG-1:0] AND_OP = 6'b100100;
   localparam logic [NB_OP_PKG-1:0] OR_OP  = 6'b100101;
   localparam logic [NB_OP_PKG-1:0] XOR_OP = 6'b100110;
   localparam logic [NB_OP_PKG-1:0] SRA_OP = 6'b000011;
   localparam logic [NB_OP_PKG-1:0] SRL_OP = 6'b000010;
   localparam logic [NB_OP_PKG-1:0] NOR_OP = 6'b100111;

   localparam logic [2:0] ST_WAIT_A  = 3'd0;
   localparam logic [2:0] ST_WAIT_B  = 3'd1;
   localparam logic [2:0] ST_WAIT_OP = 3'd2;
   localparam logic [2:0] ST_COMPUTE = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;
   localparam logic [2:0] ST_WAIT_TX = 3'd5;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_BAD_OP  = 2'b10;

   function automatic logic is_valid_op(input logic [NB_OP_PKG-1:0] op);
      case (op)
         ADD_OP, SUB_OP, AND_OP, OR_OP,
         XOR_OP, SRA_OP, SRL_OP, NOR_OP: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_alu_sequencer_timeout_counter.sv
// Inter-byte idle timer.
// Ports: i_clk, i_reset (async, active-low), i_enable (count this cycle),
//        i_clear (return to zero, has priority), o_tc (count is at
//        TIMEOUT_CYCLES-1 while enabled). TIMEOUT_CYCLES=0 keeps o_tc low.
module timeout_counter #(
   parameter int NB_TIMEOUT     = 20,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_tc
);

   localparam int                    TC_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [NB_TIMEOUT-1:0] TC_VAL = NB_TIMEOUT'(TC_INT);
   localparam logic                  ACTIVE = (TIMEOUT_CYCLES != 0);

   logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear)       cnt_d = '0;
      else if (i_enable) cnt_d = cnt_q + NB_TIMEOUT'(1);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign o_tc = ACTIVE && i_enable && (cnt_q == TC_VAL);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Byte-stream ALU sequencer: collects operand A, operand B and opcode from
// uart_rx, drives the ALU, captures its result and starts uart_tx.
// Ports: i_clk, i_reset (async, active-low); i_rx_data/i_rx_done from uart_rx;
//        i_tx_done from uart_tx; i_alu_result from the ALU;
//        o_alu_a/o_alu_b/o_alu_op to the ALU; o_tx_data/o_tx_start to uart_tx;
//        o_busy, o_error (pulse), o_err_code (held).
//
// state      | meaning
// WAIT_A     | idle, next byte is operand A
// WAIT_B     | next byte is operand B (timeout running)
// WAIT_OP    | next byte is the opcode (timeout running)
// COMPUTE    | ALU settles on latched operands, result captured
// SEND       | one-cycle start pulse to uart_tx
// WAIT_TX    | wait for uart_tx to finish; received bytes dropped
module uart_alu_sequencer
   import alu_pkg::*;
#(
   parameter int NB_DATA        = 8,
   parameter int NB_OP          = 6,
   parameter int NB_TIMEOUT     = 20,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic               i_tx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_error,
   output logic [1:0]         o_err_code
);

   logic [2:0]         state_q, state_d;
   logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic               error_q, error_d;
   logic [1:0]         err_code_q, err_code_d;
   logic               to_enable, to_clear, to_tc;

   assign to_enable = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
   // Holding the counter clear outside the frame body gives the
   // clear-on-entry-to-WAIT_A behaviour without a separate entry strobe.
   assign to_clear  = i_rx_done || !to_enable || to_tc;

   timeout_counter #(
      .NB_TIMEOUT     (NB_TIMEOUT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_enable (to_enable),
      .i_clear  (to_clear),
      .o_tc     (to_tc)
   );

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      tx_data_d  = tx_data_q;
      error_d    = 1'b0;
      err_code_d = err_code_q;
      case (state_q)
         ST_WAIT_A: begin
            if (i_rx_done) begin
               a_d     = i_rx_data;
               state_d = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            if (i_rx_done) begin
               b_d     = i_rx_data;
               state_d = ST_WAIT_OP;
            end else if (to_tc) begin
               error_d    = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_WAIT_A;
            end
         end
         ST_WAIT_OP: begin
            if (i_rx_done) begin
               if (is_valid_op(i_rx_data[NB_OP-1:0])) begin
                  op_d    = i_rx_data[NB_OP-1:0];
                  state_d = ST_COMPUTE;
               end else begin
                  error_d    = 1'b1;
                  err_code_d = ERR_BAD_OP;
                  state_d    = ST_WAIT_A;
               end
            end else if (to_tc) begin
               error_d    = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_WAIT_A;
            end
         end
         ST_COMPUTE: begin
            tx_data_d = i_alu_result;
            state_d   = ST_SEND;
         end
         ST_SEND:    state_d = ST_WAIT_TX;
         ST_WAIT_TX: if (i_tx_done) state_d = ST_WAIT_A;
         default:    state_d = ST_WAIT_A;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= ST_WAIT_A;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         tx_data_q  <= tx_data_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

   assign o_alu_a    = a_q;
   assign o_alu_b    = b_q;
   assign o_alu_op   = op_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = (state_q == ST_SEND);
   assign o_busy     = (state_q == ST_COMPUTE) || (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
   assign o_error    = error_q;
   assign o_err_code = err_code_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer with a behavioural ALU attached.
module tb_uart_alu_sequencer;
   import alu_pkg::*;

   logic       clk;
   logic       i_reset;
   logic [7:0] i_rx_data;
   logic       i_rx_done;
   logic       i_tx_done;
   logic [7:0] i_alu_result;
   logic [7:0] o_alu_a, o_alu_b, o_tx_data;
   logic [5:0] o_alu_op;
   logic       o_tx_start, o_busy, o_error;
   logic [1:0] o_err_code;

   int checks = 0;
   int errors = 0;

   uart_alu_sequencer #(
      .NB_DATA(8), .NB_OP(6), .NB_TIMEOUT(20), .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_rx_data    (i_rx_data),
      .i_rx_done    (i_rx_done),
      .i_tx_done    (i_tx_done),
      .i_alu_result (i_alu_result),
      .o_alu_a      (o_alu_a),
      .o_alu_b      (o_alu_b),
      .o_alu_op     (o_alu_op),
      .o_tx_data    (o_tx_data),
      .o_tx_start   (o_tx_start),
      .o_busy       (o_busy),
      .o_error      (o_error),
      .o_err_code   (o_err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      i_alu_result = 8'h00;
      case (o_alu_op)
         ADD_OP: i_alu_result = o_alu_a + o_alu_b;
         SUB_OP: i_alu_result = o_alu_a - o_alu_b;
         AND_OP: i_alu_result = o_alu_a & o_alu_b;
         OR_OP:  i_alu_result = o_alu_a | o_alu_b;
         XOR_OP: i_alu_result = o_alu_a ^ o_alu_b;
         SRA_OP: i_alu_result = 8'($signed(o_alu_a) >>> o_alu_b);
         SRL_OP: i_alu_result = o_alu_a >> o_alu_b;
         NOR_OP: i_alu_result = ~(o_alu_a | o_alu_b);
         default: i_alu_result = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data = b;
      i_rx_done = 1'b1;
      tick();
      i_rx_done = 1'b0;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp_res);
      send_byte(a);
      send_byte(b);
      send_byte(op);
      check({tag, "_op"},       32'(o_alu_op),   32'(op[5:0]));
      check({tag, "_pre_start"},32'(o_tx_start), 32'(0));
      check({tag, "_busy"},     32'(o_busy),     32'(1));
      tick();
      check({tag, "_start"},    32'(o_tx_start), 32'(1));
      check({tag, "_data"},     32'(o_tx_data),  32'(exp_res));
      tick();
      check({tag, "_start_end"},32'(o_tx_start), 32'(0));
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      check({tag, "_idle"},     32'(o_busy),     32'(0));
   endtask

   initial begin
      logic seen;
      i_reset   = 1'b0;
      i_rx_data = 8'h00;
      i_rx_done = 1'b0;
      i_tx_done = 1'b0;
      repeat (2) tick();
      check("rst_a",     32'(o_alu_a),    32'(0));
      check("rst_busy",  32'(o_busy),     32'(0));
      check("rst_start", 32'(o_tx_start), 32'(0));
      check("rst_err",   32'(o_error),    32'(0));
      check("rst_code",  32'(o_err_code), 32'(0));
      i_reset = 1'b1;
      tick();

      // basic ADD, SUB and SUB with wrap
      run_frame("add",  8'h0A, 8'h05, 8'h20, 8'h0F);
      check("add_state", 32'(dut.state_q), 32'(ST_WAIT_A));
      run_frame("sub",  8'h0F, 8'h05, 8'h22, 8'h0A);
      run_frame("subw", 8'h05, 8'h0F, 8'h22, 8'hF6);
      check("hold_a", 32'(o_alu_a), 32'(8'h05));

      // bad opcode
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h3F);
      check("bad_err",  32'(o_error),    32'(1));
      check("bad_code", 32'(o_err_code), 32'(2));
      check("bad_op",   32'(o_alu_op),   32'(6'h22));
      check("bad_busy", 32'(o_busy),     32'(0));
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (o_tx_start) seen = 1'b1;
      end
      check("bad_nostart", 32'(seen),       32'(0));
      check("bad_pulse",   32'(o_error),    32'(0));
      check("bad_hold",    32'(o_err_code), 32'(2));
      run_frame("badnext", 8'h03, 8'h04, 8'h20, 8'h07);

      // timeout after operand A
      send_byte(8'h0A);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (o_error) seen = 1'b1;
      end
      check("to_early", 32'(seen), 32'(0));
      tick();
      check("to_err",   32'(o_error),        32'(1));
      check("to_code",  32'(o_err_code),     32'(1));
      check("to_state", 32'(dut.state_q),    32'(ST_WAIT_A));
      tick();
      check("to_pulse", 32'(o_error), 32'(0));
      run_frame("tonext", 8'h01, 8'h01, 8'h20, 8'h02);

      // byte arriving on the expiry cycle is accepted
      send_byte(8'h0A);
      repeat (15) tick();
      send_byte(8'h05);
      check("exp_noerr", 32'(o_error), 32'(0));
      check("exp_b",     32'(o_alu_b), 32'(8'h05));
      send_byte(8'h20);
      check("exp_busy",  32'(o_busy),  32'(1));
      tick();
      check("exp_data",  32'(o_tx_data), 32'(8'h0F));
      tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;

      // bytes during WAIT_TX are dropped
      send_byte(8'h06);
      send_byte(8'h03);
      send_byte(8'h22);
      tick();
      tick();
      send_byte(8'h55);
      check("wtx_busy", 32'(o_busy),  32'(1));
      check("wtx_a",    32'(o_alu_a), 32'(8'h06));
      i_rx_data = 8'h66;
      i_rx_done = 1'b1;
      i_tx_done = 1'b1;
      tick();
      i_rx_done = 1'b0;
      i_tx_done = 1'b0;
      check("wtx_idle", 32'(o_busy),  32'(0));
      check("wtx_a2",   32'(o_alu_a), 32'(8'h06));
      run_frame("and", 8'h02, 8'h03, 8'h24, 8'h02);
      check("and_a", 32'(o_alu_a), 32'(8'h02));

      // async reset in WAIT_OP
      send_byte(8'h11);
      send_byte(8'h22);
      check("pre_rst_state", 32'(dut.state_q), 32'(ST_WAIT_OP));
      #2;
      i_reset = 1'b0;
      #1;
      check("mid_rst_a",    32'(o_alu_a),    32'(0));
      check("mid_rst_b",    32'(o_alu_b),    32'(0));
      check("mid_rst_op",   32'(o_alu_op),   32'(0));
      check("mid_rst_data", 32'(o_tx_data),  32'(0));
      check("mid_rst_code", 32'(o_err_code), 32'(0));
      tick();
      i_reset = 1'b1;
      tick();
      check("post_rst_state", 32'(dut.state_q), 32'(ST_WAIT_A));
      run_frame("postrst", 8'h03, 8'h04, 8'h20, 8'h07);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Controller that sequences the shared ALU from a byte stream instead of buttons.
- Collects three bytes from the UART receiver in order: operand A, operand B, opcode.
- Drives the ALU, captures the result and hands it to the UART transmitter.
- Sits between uart_rx/uart_tx and the ALU inside the UART top level. Validates opcodes and enforces an inter-byte timeout.

Parameters:
- NB_DATA, 8, operand/result/byte width.
- NB_OP, 6, ALU opcode width; the opcode is taken from the low NB_OP bits of the third byte.
- NB_TIMEOUT, 20, timeout counter width.
- TIMEOUT_CYCLES, 1000000, max idle cycles between bytes of one frame; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset, asynchronous, active-low.
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe from uart_rx.
- i_tx_done  in  1  one-cycle strobe from uart_tx when the byte has been fully sent.
- i_alu_result  in  NB_DATA  combinational ALU output.
- o_alu_a  out  NB_DATA  operand A register.
- o_alu_b  out  NB_DATA  operand B register.
- o_alu_op  out  NB_OP  opcode register.
- o_tx_data  out  NB_DATA  captured result for uart_tx.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- o_busy  out  1  high in COMPUTE, SEND, WAIT_TX.
- o_error  out  1  one-cycle error pulse.
- o_err_code  out  2  01 = timeout, 10 = bad opcode; held until the next error or reset.

Behaviour:
- Reset (i_reset=0, async): state WAIT_A; all outputs 0; timeout counter 0. Reset mid-frame discards partial operands.
- States and transitions:
  - WAIT_A: on i_rx_done, latch o_alu_a, go WAIT_B.
  - WAIT_B: on i_rx_done, latch o_alu_b, go WAIT_OP.
  - WAIT_OP: on i_rx_done, check i_rx_data[NB_OP-1:0] against valid set {ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111}.
    - Valid: latch o_alu_op, go COMPUTE.
    - Invalid: o_alu_op unchanged, o_error=1, o_err_code=10, go WAIT_A.
    - Upper bits i_rx_data[NB_DATA-1:NB_OP] are ignored.
  - COMPUTE: one cycle; o_tx_data <= i_alu_result; go SEND.
  - SEND: o_tx_start=1 for exactly this cycle; go WAIT_TX.
  - WAIT_TX: on i_tx_done, go WAIT_A.
- Latency: opcode strobe at cycle N → o_alu_op valid N+1 → o_tx_start and o_tx_data valid N+2.
- Operand registers hold their values after a frame until overwritten.
- Timeout counter:
  - Counts every cycle in WAIT_B and WAIT_OP; clears on each accepted byte and on entry to WAIT_A.
  - When the count reaches TIMEOUT_CYCLES-1 with no i_rx_done that cycle: o_error=1, o_err_code=01, go WAIT_A.
  - i_rx_done on the expiry cycle wins: the byte is accepted, no error.
  - Inactive when TIMEOUT_CYCLES=0.
- i_rx_done in COMPUTE, SEND or WAIT_TX: byte dropped, no state change.
- i_rx_done and i_tx_done together in WAIT_TX: go WAIT_A, byte dropped.
- i_tx_done outside WAIT_TX: ignored.
- No arithmetic inside the block. Result width is NB_DATA with no carry.

Decomposition:
- Shared package alu_pkg: opcode localparams (ADD_OP…NOR_OP), state encoding, error-code constants. The ALU and the top-level bench reuse the same opcodes.
- One sub-module: timeout_counter (enable, clear, terminal-count output, parameterized by NB_TIMEOUT and TIMEOUT_CYCLES).

Test Plan:
- Bytes 0x0A, 0x05, 0x20 (ADD) with an ALU model attached → o_tx_start pulses 2 cycles after the third strobe; o_tx_data=0x0F. After i_tx_done: state WAIT_A, o_busy=0.
- Bytes 0x0F, 0x05, 0x22 (SUB) → o_tx_data=0x0A. Repeat with 0x05, 0x0F, SUB → 0xF6 (wrap).
- Bytes 0x01, 0x02, 0x3F → o_error pulse, o_err_code=10, no o_tx_start. Then 0x03, 0x04, 0x20 → o_tx_data=0x07.
- TIMEOUT_CYCLES=16: send 0x0A, then idle 16 cycles → o_error, o_err_code=01. Next bytes 0x01, 0x01, 0x20 → o_tx_data=0x02.
- Byte 0x55 strobed during WAIT_TX, plus i_rx_done and i_tx_done in the same cycle → both bytes ignored. The following frame 0x02, 0x03, 0x24 (AND) → 0x02.
- Assert i_reset low in WAIT_OP between clock edges → outputs 0 immediately. After release, state WAIT_A.
